axi_tagctrl_r: RTL



---
 rtl/axi_tagctrl_r.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axi_tagctrl_r.sv
// axi_tagctrl_r: read path of the CHERI AXI tag controller.
// Fetches the tag line covering each read burst and merges tag, ID and error into forwarded R beats.
package axi_tagctrl_r_pkg;
  typedef struct packed {
    int unsigned AxiIdWidth;
    int unsigned AxiAddrWidth;
    int unsigned AxiDataWidth;
    int unsigned CapSize;
  } tagctrl_cfg_t;

  localparam tagctrl_cfg_t DefaultCfg = '{AxiIdWidth: 4, AxiAddrWidth: 32, AxiDataWidth: 64, CapSize: 128};

  typedef struct packed {
    logic [3:0]  a_x_id;
    logic [31:0] a_x_addr;
    logic [7:0]  a_x_len;
    logic [2:0]  a_x_size;
    logic [1:0]  a_x_burst;
  } tc_desc_t;

  typedef struct packed {
    logic [31:0] addr;
  } tc_req_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } tc_rsp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } tc_r_chan_t;
endpackage

module axi_tagctrl_r #(
  parameter axi_tagctrl_r_pkg::tagctrl_cfg_t Cfg = axi_tagctrl_r_pkg::DefaultCfg,
  parameter type tagctrl_desc_t = axi_tagctrl_r_pkg::tc_desc_t,
  parameter type tagc_req_t     = axi_tagctrl_r_pkg::tc_req_t,
  parameter type tagc_rsp_t     = axi_tagctrl_r_pkg::tc_rsp_t,
  parameter type r_chan_t       = axi_tagctrl_r_pkg::tc_r_chan_t
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  tagctrl_desc_t tagctrl_desc_i,
  input  logic          tagctrl_desc_valid_i,
  output logic          tagctrl_desc_ready_o,
  output tagc_req_t     tagc_req_o,
  output logic          tagc_req_valid_o,
  input  logic          tagc_req_ready_i,
  input  tagc_rsp_t     tagc_rsp_i,
  input  logic          tagc_rsp_valid_i,
  output logic          tagc_rsp_ready_o,
  input  r_chan_t       r_chan_mst_i,
  input  logic          r_chan_mst_valid_i,
  output logic          r_chan_mst_ready_o,
  output r_chan_t       r_chan_slv_o,
  output logic          r_chan_slv_valid_o,
  input  logic          r_chan_slv_ready_i
);

  localparam int unsigned AW        = Cfg.AxiAddrWidth;
  localparam int unsigned IW        = Cfg.AxiIdWidth;
  localparam int unsigned DW        = Cfg.AxiDataWidth;
  localparam int unsigned CB        = $clog2(Cfg.CapSize / 8);
  localparam int unsigned IB        = $clog2(DW);
  localparam int unsigned LineBytes = DW * Cfg.CapSize / 8;
  localparam logic [AW-1:0] LineMask = ~AW'(LineBytes - 1);
  localparam logic [IB-1:0] LastIdx  = IB'(DW - 1);
  localparam logic [1:0]    BurstIncr = 2'b01;

  typedef enum logic [1:0] {IDLE, TAG_REQ, TAG_WAIT, SEND_R} state_e;

  state_e          r_state;
  logic [IW-1:0]   r_id;
  logic [AW-1:0]   r_addr;
  logic [2:0]      r_size;
  logic            r_incr;
  logic [DW-1:0]   r_tag_line;
  logic [1:0]      r_tag_err;

  logic [IB-1:0]   w_idx;
  logic [AW-1:0]   w_step;
  logic [AW-1:0]   w_next_addr;
  logic            w_cross;
  logic            w_beat;
  logic            w_unused;

  assign w_idx       = r_addr[CB +: IB];
  assign w_step      = AW'(1) << r_size;
  assign w_next_addr = r_incr ? ((r_addr + w_step) & ~(w_step - AW'(1))) : r_addr;
  // FIXED bursts never leave their line, so only INCR can trigger a refetch
  assign w_cross     = r_incr && (w_idx == LastIdx) && (w_next_addr[CB-1:0] == '0);
  assign w_beat      = (r_state == SEND_R) && r_chan_mst_valid_i && r_chan_slv_ready_i;
  assign w_unused    = ^tagctrl_desc_i.a_x_len;

  assign tagctrl_desc_ready_o = (r_state == IDLE) && !rst_i;
  assign tagc_req_valid_o     = (r_state == TAG_REQ) && !rst_i;
  assign tagc_rsp_ready_o     = (r_state == TAG_WAIT) && !rst_i;
  assign r_chan_mst_ready_o   = (r_state == SEND_R) && r_chan_slv_ready_i && !rst_i;
  assign r_chan_slv_valid_o   = (r_state == SEND_R) && r_chan_mst_valid_i && !rst_i;

  always_comb begin
    tagc_req_o      = '0;
    tagc_req_o.addr = r_addr & LineMask;
  end

  always_comb begin
    r_chan_slv_o = '0;
    if (r_state == SEND_R) begin
      r_chan_slv_o      = r_chan_mst_i;
      r_chan_slv_o.id   = r_id;
      r_chan_slv_o.user = r_tag_line[w_idx];
      r_chan_slv_o.resp = (r_tag_err != 2'b00) ? r_tag_err : r_chan_mst_i.resp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_incr     <= 1'b0;
      r_tag_line <= '0;
      r_tag_err  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tagctrl_desc_valid_i) begin
            r_id      <= tagctrl_desc_i.a_x_id;
            r_addr    <= tagctrl_desc_i.a_x_addr;
            r_size    <= tagctrl_desc_i.a_x_size;
            r_incr    <= (tagctrl_desc_i.a_x_burst == BurstIncr);
            r_tag_err <= '0;
            r_state   <= TAG_REQ;
          end
        end
        TAG_REQ: begin
          if (tagc_req_ready_i) r_state <= TAG_WAIT;
        end
        TAG_WAIT: begin
          if (tagc_rsp_valid_i) begin
            r_tag_line <= tagc_rsp_i.data;
            // first error of the burst is kept across refetches
            if (tagc_rsp_i.resp != 2'b00 && r_tag_err == 2'b00) r_tag_err <= tagc_rsp_i.resp;
            r_state <= SEND_R;
          end
        end
        SEND_R: begin
          if (w_beat) begin
            r_addr <= w_next_addr;
            if (r_chan_mst_i.last) r_state <= IDLE;
            else if (w_cross)      r_state <= TAG_REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
